// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Oversampled UART receiver with configurable width, parity and
//            stop bits, start-glitch rejection and 3-sample majority voting.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int SB         = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] c_S_MID  = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] c_S_CAP0 = SW'(OVS - 3);
    localparam logic [SW-1:0] c_S_CAP1 = SW'(OVS - 2);
    localparam logic [SW-1:0] c_S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] c_S_ONE  = SW'(1);
    localparam logic [NW-1:0] c_N_DLST = NW'(DBIT - 1);
    localparam logic [NW-1:0] c_N_SLST = NW'(SB - 1);
    localparam logic [NW-1:0] c_N_ONE  = NW'(1);
    localparam logic          c_PEN    = (PARITY_EN != 0);
    localparam logic          c_ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_sync;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_shift, w_shift;
    logic            r_cap0, w_cap0;
    logic            r_cap1, w_cap1;
    logic            r_par_flag, w_par_flag;
    logic            r_frm_flag, w_frm_flag;
    logic [DBIT-1:0] r_dout, w_dout;
    logic            r_par_err, w_par_err;
    logic            r_frm_err, w_frm_err;
    logic            r_done, w_done;
    logic            w_rx_s;
    logic            w_vote;

    assign w_rx_s = r_sync[1];
    assign w_vote = (r_cap0 & r_cap1) | (r_cap0 & w_rx_s) | (r_cap1 & w_rx_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= 2'b11;
            r_state    <= S_IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_cap0     <= 1'b0;
            r_cap1     <= 1'b0;
            r_par_flag <= 1'b0;
            r_frm_flag <= 1'b0;
            r_dout     <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_state    <= w_state;
            r_s        <= w_s;
            r_n        <= w_n;
            r_shift    <= w_shift;
            r_cap0     <= w_cap0;
            r_cap1     <= w_cap1;
            r_par_flag <= w_par_flag;
            r_frm_flag <= w_frm_flag;
            r_dout     <= w_dout;
            r_par_err  <= w_par_err;
            r_frm_err  <= w_frm_err;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_s        = r_s;
        w_n        = r_n;
        w_shift    = r_shift;
        w_cap0     = r_cap0;
        w_cap1     = r_cap1;
        w_par_flag = r_par_flag;
        w_frm_flag = r_frm_flag;
        w_dout     = r_dout;
        w_par_err  = r_par_err;
        w_frm_err  = r_frm_err;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state    = S_START;
                    w_s        = '0;
                    w_par_flag = 1'b0;
                    w_frm_flag = 1'b0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (r_s == c_S_MID) begin
                        w_s = '0;
                        // A high line at mid start bit is noise, not a frame
                        if (w_rx_s) begin
                            w_state = S_IDLE;
                        end else begin
                            w_state = S_DATA;
                            w_n     = '0;
                        end
                    end else begin
                        w_s = r_s + c_S_ONE;
                    end
                end
            end
            default: begin
                if (s_tick) begin
                    if (r_s == c_S_CAP0) w_cap0 = w_rx_s;
                    if (r_s == c_S_CAP1) w_cap1 = w_rx_s;
                    if (r_s == c_S_LAST) begin
                        w_s = '0;
                        case (r_state)
                            S_DATA: begin
                                w_shift = {w_vote, r_shift[DBIT-1:1]};
                                if (r_n == c_N_DLST) begin
                                    w_n     = '0;
                                    w_state = c_PEN ? S_PARITY : S_STOP;
                                end else begin
                                    w_n = r_n + c_N_ONE;
                                end
                            end
                            S_PARITY: begin
                                w_par_flag = w_vote ^ (^r_shift) ^ c_ODD;
                                w_n        = '0;
                                w_state    = S_STOP;
                            end
                            S_STOP: begin
                                w_frm_flag = r_frm_flag | ~w_vote;
                                if (r_n == c_N_SLST) begin
                                    w_state   = S_IDLE;
                                    w_n       = '0;
                                    w_dout    = r_shift;
                                    w_par_err = r_par_flag;
                                    w_frm_err = r_frm_flag | ~w_vote;
                                    w_done    = 1'b1;
                                end else begin
                                    w_n = r_n + c_N_ONE;
                                end
                            end
                            default: w_state = S_IDLE;
                        endcase
                    end else begin
                        w_s = r_s + c_S_ONE;
                    end
                end
            end
        endcase
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign parity_err   = r_par_err;
    assign frame_err    = r_frm_err;
    assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8-bit receive interface. It adds:
- configurable data width, oversampling ratio, optional parity and 1 or 2 stop bits;
- an input synchroniser, start-bit glitch rejection and 3-sample majority voting;
- parity and framing error reporting.

It sits between the baud-rate tick generator (`s_tick`) and the receive FIFO / host interface.

## Interface
- `DBIT`, 8, data bits per frame, legal 5..9
- `OVS`, 16, `s_tick` pulses per bit period, even, legal 8..32
- `PARITY_EN`, 0, 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity (ignored when `PARITY_EN`=0)
- `SB`, 1, stop bits checked, 1 or 2

Ports:
- `clk`  input  1  single system clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `rx`  input  1  asynchronous serial line, idle high
- `s_tick`  input  1  one-`clk` oversampling enable pulse, `OVS` per bit
- `rx_done_tick`  output  1  one-cycle pulse: frame complete, outputs valid
- `dout`  output  `DBIT`  received data, LSB first on line, `dout[0]` = first data bit
- `parity_err`  output  1  last frame's parity mismatched (0 when `PARITY_EN`=0)
- `frame_err`  output  1  last frame had a stop bit sampled low
- `busy`  output  1  high whenever the FSM is not in `idle`

## Operation
- **Synchroniser:** `rx` passes through 2 flops (both reset to 1). All logic uses the synchronised `rx_s`.
- **FSM states:** `idle`, `start`, `data`, `parity`, `stop`. Tick counter `s` is `$clog2(OVS)` bits wide. Bit counter `n` counts data bits, then stop bits.
- **`idle`:**
  - `rx_s`=0 → go to `start`, `s`=0.
  - This transition happens on `clk`, independent of `s_tick`.
- **`start`:** on each `s_tick`, `s`++. At `s`==`OVS/2-1` (mid start bit):
  - `rx_s`=1 → glitch: return to `idle`; no outputs change and no `rx_done_tick`.
  - `rx_s`=0 → go to `data`, `s`=0, `n`=0.
- **Bit sampling (`data`, `parity`, `stop`):**
  - `rx_s` is captured on the ticks where `s`==`OVS-3` and `s`==`OVS-2`.
  - On the tick with `s`==`OVS-1`, the bit value is the majority of those two captures and the current `rx_s`.
  - On that same tick `s`→0; otherwise `s`++ per tick.
- **`data`:**
  - Each voted bit is shifted into a `DBIT`-wide shift register from the MSB side (right shift).
  - After the `DBIT`-th bit → `parity` if `PARITY_EN`, else `stop`, with `n`=0.
- **`parity`:**
  - Voted bit XOR (XOR-reduce of data) XOR `PARITY_ODD` = error flag (1 = mismatch).
  - Then go to `stop`, `n`=0.
- **`stop`:**
  - Each voted stop bit that is 0 sets an internal frame-error flag.
  - After `SB` stop bits → `idle`, and the frame completes.
- **Frame completion (registered, same edge):**
  - `dout` ← shift register.
  - `parity_err` ← parity flag.
  - `frame_err` ← frame flag.
  - `rx_done_tick` ← 1.
- **Output hold:** `dout`, `parity_err` and `frame_err` keep their values until the next completion. Internal flags clear on entry to `start`.
- **Break condition:** a line held low is reported as `frame_err`=1 with `dout`=0. The FSM then waits in `idle` until `rx_s` goes low again. A line still low re-enters `start` immediately, which is accepted behaviour.
- **`s_tick` absent:** the FSM and counters hold; nothing times out.

## Timing
- **Reset (`reset`=0, asynchronous):**
  - state `idle`, `s`=0, `n`=0, shift register 0;
  - `dout`=0, `parity_err`=0, `frame_err`=0, `rx_done_tick`=0, `busy`=0;
  - sync flops=1.
- **Reset mid-frame:** the frame is discarded with no `rx_done_tick`. Reception restarts on the next falling edge after release.
- **Falling-edge detection:** 2 `clk` (synchroniser) + 1 `clk` to `start`.
- **Frame latency:** from the `start` entry to the `rx_done_tick` assertion = `OVS/2` + (`DBIT`+`PARITY_EN`+`SB`)·`OVS` ticks + 1 `clk`.
- **`rx_done_tick`:** exactly 1 `clk` wide. It is never asserted on two consecutive cycles.
- **`busy`:**
  - rises 1 `clk` after `rx_s` falls;
  - falls in the same cycle `rx_done_tick` rises, or on a glitch abort.
- **Back-to-back frames:** no idle gap is required. A start edge arriving during the second half of the last stop bit is detected once `idle` is re-entered, one `clk` after completion.

## Test plan
- **Baseline 8N1:** defaults, `OVS`=16, send 0xA5 then 0x3C back-to-back → two `rx_done_tick` pulses, `dout`=0xA5 then 0x3C, both error flags 0.
- **Even parity error:** `PARITY_EN`=1, `PARITY_ODD`=0, send 0x81 with parity bit 1 → `dout`=0x81, `parity_err`=1. Resend with parity 0 → `parity_err`=0.
- **Start glitch:** pulse `rx` low for 4 ticks only → no `rx_done_tick`, `busy` returns to 0, outputs unchanged. A following 0x55 is received correctly.
- **Majority vote:** during data bit 3 of 0x00, force `rx` high on exactly one of the 3 sample ticks → `dout`=0x00.
- **Odd parity, 2 stop bits:** `DBIT`=7, `PARITY_ODD`=1, `PARITY_EN`=1, `SB`=2, send 0x7F with second stop bit 0 → `dout`=0x7F, `parity_err`=0, `frame_err`=1. The done pulse lands at tick 8+10·16 after `start` entry.
- **Reset mid-frame:** assert `reset`=0 during data bit 4 → all outputs 0 immediately, no done pulse. After release, 0xC3 is received with `dout`=0xC3.
